// File: rtl/snake_pkg.sv
// Shared snake-core constants: packed cell coordinates and the segment FIFO geometry.
package snake_pkg;
  localparam int FIFO_DATA_W = 14;
  localparam int FIFO_ADDR_W = 13;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module sync_fifo_ram
  import snake_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1<<ADDR_W];

  // Array left unreset so it maps onto block RAM.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read register holds until the next accepted pop; cleared by reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, used for snake body segments.
module sync_fifo
  import snake_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic [CNT_W-1:0]  fifo_counter
);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_ok, rd_ok;

  assign buf_empty = (fifo_counter == '0);
  assign buf_full  = (fifo_counter == DEPTH);
  // Flags come from the pre-edge count, so empty+rd+wr accepts only the write.
  assign wr_ok     = wr_en && !buf_full;
  assign rd_ok     = rd_en && !buf_empty;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   fifo_counter <= fifo_counter + 1'b1;
        2'b01:   fifo_counter <= fifo_counter - 1'b1;
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

  sync_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (buf_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (buf_out)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
module tb_sync_fifo;
  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [13:0] buf_in;
  logic        wr_en, rd_en;
  logic [13:0] buf_out;
  logic        buf_empty, buf_full;
  logic [13:0] fifo_counter;

  int checks   = 0;
  int failures = 0;

  sync_fifo dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0; buf_in = '0;
    iRST_N = 0;
    step();
    iRST_N = 1;
  endtask

  task automatic test_reset();
    wr_en = 0; rd_en = 0; buf_in = '0;
    iRST_N = 0;
    #3;
    checks++;
    if (fifo_counter !== 14'd0 || buf_empty !== 1'b1 || buf_full !== 1'b0 || buf_out !== 14'd0) begin
      failures++;
      $display("FAIL reset: cnt=%0d empty=%b full=%b out=%0d, want cnt=0 empty=1 full=0 out=0",
               fifo_counter, buf_empty, buf_full, buf_out);
    end
    step();
    iRST_N = 1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1; buf_in = 14'(3231 + i);
      step();
    end
    wr_en = 0;
    checks++;
    if (fifo_counter !== 14'd7 || buf_empty !== 1'b0 || buf_full !== 1'b0) begin
      failures++;
      $display("FAIL basic_fill: cnt=%0d empty=%b full=%b, want 7 0 0", fifo_counter, buf_empty, buf_full);
    end
    for (int i = 0; i < 7; i++) begin
      rd_en = 1;
      step();
      rd_en = 0;
      checks++;
      if (buf_out !== 14'(3231 + i)) begin
        failures++;
        $display("FAIL basic_pop%0d: got %0d want %0d", i, buf_out, 3231 + i);
      end
    end
    checks++;
    if (buf_empty !== 1'b1 || fifo_counter !== 14'd0) begin
      failures++;
      $display("FAIL basic_drain: cnt=%0d empty=%b, want 0 1", fifo_counter, buf_empty);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_en = 1;
    step(); step();
    rd_en = 0;
    checks++;
    if (buf_out !== 14'd0 || fifo_counter !== 14'd0 || buf_empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_read: out=%0d cnt=%0d empty=%b, want 0 0 1", buf_out, fifo_counter, buf_empty);
    end
    // simultaneous rd+wr on empty: only the write lands, output untouched
    rd_en = 1; wr_en = 1; buf_in = 14'd77;
    step();
    rd_en = 0; wr_en = 0;
    checks++;
    if (buf_out !== 14'd0 || fifo_counter !== 14'd1) begin
      failures++;
      $display("FAIL empty_rdwr: out=%0d cnt=%0d, want 0 1", buf_out, fifo_counter);
    end
    rd_en = 1;
    step();
    rd_en = 0;
    checks++;
    if (buf_out !== 14'd77 || buf_empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_rdwr_pop: out=%0d empty=%b, want 77 1", buf_out, buf_empty);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    wr_en = 1;
    for (int i = 0; i < 8192; i++) begin
      buf_in = 14'(i);
      step();
    end
    checks++;
    if (buf_full !== 1'b1 || fifo_counter !== 14'd8192) begin
      failures++;
      $display("FAIL full_flag: full=%b cnt=%0d, want 1 8192", buf_full, fifo_counter);
    end
    buf_in = 14'h3FFF;
    step();
    wr_en = 0;
    checks++;
    if (buf_full !== 1'b1 || fifo_counter !== 14'd8192) begin
      failures++;
      $display("FAIL full_extra_push: full=%b cnt=%0d, want 1 8192", buf_full, fifo_counter);
    end
    // full + rd+wr: only the read is accepted
    rd_en = 1; wr_en = 1; buf_in = 14'h3FFF;
    step();
    wr_en = 0;
    checks++;
    if (buf_out !== 14'd0 || fifo_counter !== 14'd8191 || buf_full !== 1'b0) begin
      failures++;
      $display("FAIL full_rdwr: out=%0d cnt=%0d full=%b, want 0 8191 0", buf_out, fifo_counter, buf_full);
    end
    for (int i = 1; i < 8192; i++) begin
      step();
      if (buf_out !== 14'(i)) begin
        bad++;
        if (bad < 5) $display("FAIL full_pop%0d: got %0d want %0d", i, buf_out, i);
      end
    end
    rd_en = 0;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (buf_empty !== 1'b1 || fifo_counter !== 14'd0) begin
      failures++;
      $display("FAIL full_drain: empty=%b cnt=%0d, want 1 0", buf_empty, fifo_counter);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; buf_in = 14'(100 + i);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      wr_en = 1; rd_en = 1; buf_in = 14'(200 + k);
      step();
      checks++;
      if (buf_out !== 14'(100 + k) || fifo_counter !== 14'd5) begin
        failures++;
        $display("FAIL b2b%0d: out=%0d cnt=%0d, want %0d 5", k, buf_out, fifo_counter, 100 + k);
      end
    end
    wr_en = 0;
    for (int k = 0; k < 5; k++) begin
      int exp;
      exp = (k < 2) ? 103 + k : 200 + k - 2;
      step();
      checks++;
      if (buf_out !== 14'(exp)) begin
        failures++;
        $display("FAIL b2b_drain%0d: got %0d want %0d", k, buf_out, exp);
      end
    end
    rd_en = 0;
  endtask

  task automatic test_wrap();
    logic [13:0] q[$];
    logic [13:0] exp;
    int bad = 0, maxcnt = 0, nxt = 0;
    // prime 3 deep, then push+pop every cycle, then drain
    for (int i = 0; i < 10000 + 3; i++) begin
      wr_en = (nxt < 10000);
      rd_en = (i >= 3);
      buf_in = 14'((nxt * 7 + 5) & 16'h3FFF);
      if (wr_en) begin q.push_back(buf_in); nxt++; end
      step();
      if (rd_en) begin
        exp = q.pop_front();
        if (buf_out !== exp) begin
          bad++;
          if (bad < 5) $display("FAIL wrap_pop%0d: got %0d want %0d", i, buf_out, exp);
        end
      end
      if (int'(fifo_counter) > maxcnt) maxcnt = int'(fifo_counter);
    end
    wr_en = 0; rd_en = 0;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (maxcnt > 4) begin
      failures++;
      $display("FAIL wrap_depth: max count %0d, want <= 4", maxcnt);
    end
    checks++;
    if (buf_empty !== 1'b1 || q.size() != 0) begin
      failures++;
      $display("FAIL wrap_end: empty=%b left=%0d, want 1 0", buf_empty, q.size());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; buf_in = 14'(500 + i);
      step();
    end
    wr_en = 0; rd_en = 1;
    step();
    rd_en = 0;
    checks++;
    if (buf_out !== 14'd500 || fifo_counter !== 14'd2) begin
      failures++;
      $display("FAIL areset_pre: out=%0d cnt=%0d, want 500 2", buf_out, fifo_counter);
    end
    #2 iRST_N = 0;
    #1;
    checks++;
    if (fifo_counter !== 14'd0 || buf_empty !== 1'b1 || buf_out !== 14'd0) begin
      failures++;
      $display("FAIL areset: cnt=%0d empty=%b out=%0d, want 0 1 0", fifo_counter, buf_empty, buf_out);
    end
    step();
    iRST_N = 1;
    rd_en = 1;
    step();
    rd_en = 0;
    checks++;
    if (buf_out !== 14'd0 || fifo_counter !== 14'd0) begin
      failures++;
      $display("FAIL areset_after: out=%0d cnt=%0d, want 0 0", buf_out, fifo_counter);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_full();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
